// File: rtl/module_arbitro_hamming_pkg.sv
// pkg_hamming: Hamming(7,4) word types and arbiter FSM states
package pkg_hamming;
   typedef logic [6:0] palabra_t;
   typedef logic [3:0] dato_t;
   typedef logic [2:0] sindrome_t;
   typedef enum logic [1:0] {IDLE, CHECK, RESP} arb_state_t;
endpackage

// File: rtl/module_arbitro_hamming_rr_pick.sv
// module_rr_pick: first set request at or after ptr (wrapping) as one-hot grant plus index
module module_rr_pick #(
   parameter int N = 2,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);
   // Scan farthest offset first so the closest valid requester wins.
   always_comb begin
      idx = '0;
      any = 1'b0;
      for (int o = N - 1; o >= 0; o--)
         if (req[(int'(ptr) + o) % N]) begin
            idx = IW'((int'(ptr) + o) % N);
            any = 1'b1;
         end
      gnt = any ? N'(1) << idx : '0;
   end
endmodule

// File: rtl/module_arbitro_hamming.sv
// module_arbitro_hamming: round-robin sharing of one Hamming(7,4) check path; HAM_ERR_CNT_EN adds error counter
module module_arbitro_hamming
   import pkg_hamming::*;
#(
   parameter int N_REQ = 2,
   parameter int CNT_W = 8,
   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [7*N_REQ-1:0] req_palabra,
   output logic [N_REQ-1:0]   req_ready,
   output palabra_t           cw_o,
   input  sindrome_t          sindrome_i,
   input  dato_t              dato_corr_i,
   output logic               resp_valid,
   input  logic               resp_ready,
   output logic [IW-1:0]      resp_id,
   output dato_t              resp_dato,
   output sindrome_t          resp_sindrome,
   output logic               resp_error,
   output logic               busy,
   output logic [CNT_W-1:0]   err_cnt
);
   arb_state_t st;
   logic [IW-1:0] ptr, idx;
   logic [N_REQ-1:0] gnt;
   logic any;
   module_rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
      .req(req_valid),
      .ptr(ptr),
      .gnt(gnt),
      .idx(idx),
      .any(any)
   );
   assign req_ready = (st == IDLE) ? gnt : '0;
   assign busy = st != IDLE;
   always_ff @(posedge clk)
      if (rst) begin
         st <= IDLE;
         ptr <= '0;
         cw_o <= '0;
         resp_valid <= 1'b0;
         resp_id <= '0;
         resp_dato <= '0;
         resp_sindrome <= '0;
         resp_error <= 1'b0;
      end else
         case (st)
            IDLE:
               if (any) begin
                  cw_o <= req_palabra[7*idx +: 7];
                  resp_id <= idx;
                  ptr <= (int'(idx) == N_REQ - 1) ? '0 : idx + 1'b1;
                  st <= CHECK;
               end
            CHECK: begin
               resp_sindrome <= sindrome_i;
               resp_dato <= dato_corr_i;
               resp_error <= |sindrome_i;
               resp_valid <= 1'b1;
               st <= RESP;
            end
            RESP:
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  st <= IDLE;
               end
            default: st <= IDLE;
         endcase
`ifdef HAM_ERR_CNT_EN
   always_ff @(posedge clk)
      if (rst) err_cnt <= '0;
      else if (st == CHECK && |sindrome_i && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
`else
   assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_module_arbitro_hamming.sv
// tb_module_arbitro_hamming: table vectors, corner sequences and randomized model check of the arbiter
module tb_module_arbitro_hamming;
   localparam int N = 2;
   localparam int CW = 2;
   localparam int CMAX = (1 << CW) - 1;
   logic clk = 1'b0;
   logic rst;
   logic [N-1:0] req_valid, req_ready;
   logic [7*N-1:0] req_palabra;
   logic [6:0] cw_o;
   logic [2:0] sindrome_i, resp_sindrome;
   logic [3:0] dato_corr_i, resp_dato;
   logic resp_valid, resp_ready, resp_error, busy;
   logic [0:0] resp_id;
   logic [CW-1:0] err_cnt;
   int n_cmp = 0;
   int n_bad = 0;
   int n_err = 0;
   int mptr = 0;
   always #5 clk = ~clk;
   module_arbitro_hamming #(.N_REQ(N), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_palabra(req_palabra),
      .req_ready(req_ready), .cw_o(cw_o), .sindrome_i(sindrome_i), .dato_corr_i(dato_corr_i),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_dato(resp_dato),
      .resp_sindrome(resp_sindrome), .resp_error(resp_error), .busy(busy), .err_cnt(err_cnt)
   );
   // Reference check path: syndrome is the XOR of the 1-based positions of set bits.
   function automatic logic [6:0] ham(input logic [6:0] w);
      logic [2:0] s = 3'd0;
      logic [6:0] c = w;
      for (int p = 1; p <= 7; p++) if (w[p-1]) s ^= 3'(p);
      if (s != 3'd0) c[s-1] = ~c[s-1];
      return {s, c[6], c[5], c[4], c[2]};
   endfunction
   always_comb {sindrome_i, dato_corr_i} = ham(cw_o);
   function automatic logic [31:0] cnt_exp(input int n);
`ifdef HAM_ERR_CNT_EN
      return (n > CMAX) ? CMAX : n;
`else
      return (n < 0) ? 1 : 0;
`endif
   endfunction
   function automatic int pick(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask
   task automatic reset_dut();
      @(negedge clk);
      rst = 1'b1;
      req_valid = '0;
      resp_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      n_err = 0;
      mptr = 0;
   endtask
   task automatic single(input int id, input logic [6:0] w, input logic [2:0] syn,
                         input logic [3:0] dato, input logic err);
      @(negedge clk);
      req_valid = N'(1 << id);
      req_palabra[7*id +: 7] = w;
      resp_ready = 1'b0;
      #1;
      chk("grant", req_ready, 32'(1 << id));
      chk("idle_busy", busy, 0);
      @(negedge clk);
      req_valid = '0;
      #1;
      chk("check_busy", busy, 1);
      chk("check_rv", resp_valid, 0);
      chk("check_ready", req_ready, 0);
      chk("cw_o", cw_o, w);
      @(negedge clk);
      #1;
      if (err) n_err++;
      chk("rv", resp_valid, 1);
      chk("id", resp_id, id);
      chk("dato", resp_dato, dato);
      chk("sindrome", resp_sindrome, syn);
      chk("error", resp_error, err);
      chk("err_cnt", err_cnt, cnt_exp(n_err));
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      #1;
      chk("done_rv", resp_valid, 0);
      chk("done_busy", busy, 0);
      mptr = (id + 1) % N;
   endtask
   typedef struct {
      int id;
      logic [6:0] w;
      logic [2:0] syn;
      logic [3:0] dato;
      logic err;
   } vec_t;
   vec_t tbl[6];
   int ids[$];
   initial begin
      rst = 1'b1;
      req_valid = '0;
      req_palabra = '0;
      resp_ready = 1'b0;
      tbl[0] = '{0, 7'b0000000, 3'd0, 4'h0, 1'b0};
      tbl[1] = '{1, 7'b0000001, 3'd1, 4'h0, 1'b1};
      tbl[2] = '{0, 7'b1111111, 3'd0, 4'hF, 1'b0};
      tbl[3] = '{1, 7'b1101111, 3'd5, 4'hF, 1'b1};
      tbl[4] = '{0, 7'b0000100, 3'd3, 4'h0, 1'b1};
      tbl[5] = '{1, 7'b0000111, 3'd0, 4'h1, 1'b0};
      reset_dut();
      #1;
      chk("rst_ready", req_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rv", resp_valid, 0);
      chk("rst_cw", cw_o, 0);
      chk("rst_id", resp_id, 0);
      chk("rst_dato", resp_dato, 0);
      chk("rst_syn", resp_sindrome, 0);
      chk("rst_err", resp_error, 0);
      chk("rst_cnt", err_cnt, 0);
      for (int i = 0; i < 6; i++) single(tbl[i].id, tbl[i].w, tbl[i].syn, tbl[i].dato, tbl[i].err);
      // Backpressure: response held for 5 cycles while the other requester waits.
      @(negedge clk);
      req_valid = 2'b01;
      req_palabra[6:0] = 7'b1101111;
      #1;
      chk("bp_grant", req_ready, 2'b01);
      @(negedge clk);
      req_valid = 2'b11;
      #1;
      chk("bp_check_ready", req_ready, 0);
      n_err++;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         chk("bp_rv", resp_valid, 1);
         chk("bp_dato", resp_dato, 4'hF);
         chk("bp_syn", resp_sindrome, 3'd5);
         chk("bp_err", resp_error, 1);
         chk("bp_id", resp_id, 0);
         chk("bp_ready", req_ready, 0);
         chk("bp_busy", busy, 1);
      end
      resp_ready = 1'b1;
      req_valid = '0;
      @(negedge clk);
      resp_ready = 1'b0;
      #1;
      chk("bp_release", busy, 0);
      chk("bp_cnt", err_cnt, cnt_exp(n_err));
      // Reset while in CHECK drops the word.
      @(negedge clk);
      req_valid = 2'b01;
      req_palabra[6:0] = 7'b0000001;
      #1;
      chk("mid_grant", req_ready, 2'b01);
      @(negedge clk);
      req_valid = '0;
      rst = 1'b1;
      #1;
      chk("mid_busy", busy, 1);
      @(negedge clk);
      rst = 1'b0;
      n_err = 0;
      mptr = 0;
      #1;
      chk("mid_idle", busy, 0);
      chk("mid_cnt", err_cnt, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         chk("mid_no_resp", resp_valid, 0);
      end
      for (int i = 0; i < 5; i++) single((i + 1) % N, 7'b0000001, 3'd1, 4'h0, 1'b1);
      chk("sat_cnt", err_cnt, cnt_exp(5));
      // Contention: both requesters always valid, consumer always ready.
      @(negedge clk);
      req_valid = 2'b11;
      req_palabra = {7'b1111111, 7'b0000111};
      resp_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         #1;
         if (resp_valid) begin
            ids.push_back(int'(resp_id));
            chk("cont_dato", resp_dato, resp_id ? 4'hF : 4'h1);
         end
         @(negedge clk);
      end
      req_valid = '0;
      resp_ready = 1'b0;
      chk("cont_count", ids.size(), 4);
      for (int k = 0; k < ids.size() && k < 4; k++) chk("cont_order", ids[k], k % 2);
      mptr = 0;
      // Randomized run against a transaction-level model.
      begin
         int phase = 0;
         int e_id = 0;
         logic [6:0] e = '0;
         for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (c < 590) begin
               req_valid = N'($urandom);
               req_palabra = (7*N)'({$urandom, $urandom});
               resp_ready = ($urandom_range(3) != 0);
            end else begin
               req_valid = '0;
               resp_ready = 1'b1;
            end
            #1;
            chk("r_busy", busy, phase != 0);
            chk("r_rv", resp_valid, phase == 2);
            chk("r_cnt", err_cnt, cnt_exp(n_err));
            if (phase == 0 && req_valid != '0) begin
               e_id = pick(req_valid, mptr);
               chk("r_grant", req_ready, 32'(1 << e_id));
               e = ham(req_palabra[7*e_id +: 7]);
               mptr = (e_id + 1) % N;
               phase = 1;
            end else if (phase == 0) begin
               chk("r_nogrant", req_ready, 0);
            end else if (phase == 1) begin
               chk("r_ready_check", req_ready, 0);
               if (e[6:4] != 3'd0) n_err++;
               phase = 2;
            end else begin
               chk("r_id", resp_id, e_id);
               chk("r_syn", resp_sindrome, e[6:4]);
               chk("r_dato", resp_dato, e[3:0]);
               chk("r_err", resp_error, e[6:4] != 3'd0);
               if (resp_ready) phase = 0;
            end
         end
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
